// File: rtl/led_code_pkg.sv
// Shared definitions for the LED blink-code transmitter: FSM state encoding
// and phase counter width.
package led_code_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_OFF  = 2'd2,
        S_GAP  = 2'd3
    } state_t;

    localparam int PHASE_W = 8;

endpackage

// File: rtl/led_blink_code_tx_tick_gen.sv
// Prescaler for the blink-code transmitter: free-running 0..TICK_MAX counter,
// tick asserted in the cycle the count sits at TICK_MAX; clr restarts it at 0.
module tick_gen #(
    parameter int unsigned TICK_MAX = 12500000 - 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    logic [31:0] count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr || (count == TICK_MAX)) begin
            count <= '0;
        end else begin
            count <= count + 32'd1;
        end
    end

    assign tick = (count == TICK_MAX);

endmodule

// File: rtl/led_blink_code_tx.sv
// Sends a 4-bit value on one LED as N short blinks (0 -> one long blink),
// followed by a low gap, then pulses done for one cycle.
//
//  state  | meaning
//  -------+-----------------------------------------------------------
//  S_IDLE | waiting for start; done pulses here on the first cycle back
//  S_ON   | LED high for ON_TICKS (LONG_TICKS for a value-0 code)
//  S_OFF  | LED low for OFF_TICKS after each blink
//  S_GAP  | LED low for GAP_TICKS after the last blink
module led_blink_code_tx #(
    parameter int unsigned TICK_MAX   = 12500000 - 1,
    parameter int unsigned ON_TICKS   = 3,
    parameter int unsigned OFF_TICKS  = 3,
    parameter int unsigned LONG_TICKS = 10,
    parameter int unsigned GAP_TICKS  = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] value,
    output logic       busy,
    output logic       done,
    output logic       led
);

    import led_code_pkg::*;

    localparam logic [PHASE_W-1:0] ON_LAST   = PHASE_W'(ON_TICKS - 1);
    localparam logic [PHASE_W-1:0] OFF_LAST  = PHASE_W'(OFF_TICKS - 1);
    localparam logic [PHASE_W-1:0] LONG_LAST = PHASE_W'(LONG_TICKS - 1);
    localparam logic [PHASE_W-1:0] GAP_LAST  = PHASE_W'(GAP_TICKS - 1);

    state_t             state, state_nx;
    logic [3:0]         rem, rem_nx;
    logic               long_code, long_nx;
    logic [PHASE_W-1:0] phase, phase_nx;
    logic               done_nx;
    logic               accept;
    logic               tick;

    tick_gen #(
        .TICK_MAX(TICK_MAX)
    ) u_tick_gen (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .tick (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            rem       <= '0;
            long_code <= 1'b0;
            phase     <= '0;
            led       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_nx;
            rem       <= rem_nx;
            long_code <= long_nx;
            phase     <= phase_nx;
            led       <= (state_nx == S_ON);
            busy      <= (state_nx != S_IDLE);
            done      <= done_nx;
        end
    end

    always_comb begin
        state_nx = state;
        rem_nx   = rem;
        long_nx  = long_code;
        phase_nx = phase;
        done_nx  = 1'b0;
        accept   = 1'b0;

        if (tick && (state != S_IDLE)) begin
            phase_nx = phase + PHASE_W'(1);
        end

        case (state)
            S_IDLE: begin
                if (start) begin
                    accept   = 1'b1;
                    rem_nx   = value;
                    long_nx  = (value == 4'd0);
                    state_nx = S_ON;
                end
            end
            S_ON: begin
                if (tick && (phase == (long_code ? LONG_LAST : ON_LAST))) begin
                    state_nx = S_OFF;
                    rem_nx   = (rem == 4'd0) ? rem : rem - 4'd1;
                end
            end
            S_OFF: begin
                if (tick && (phase == OFF_LAST)) begin
                    state_nx = (rem != 4'd0) ? S_ON : S_GAP;
                end
            end
            S_GAP: begin
                if (tick && (phase == GAP_LAST)) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // every interval is timed from a fresh phase count
        if (state_nx != state) begin
            phase_nx = '0;
        end
    end

endmodule

// File: tb/tb_led_blink_code_tx.sv
// Scoreboard bench for led_blink_code_tx: accepted codes are queued with their
// accept cycle, and a monitor checks the LED waveform, busy and done timing.
module tb_led_blink_code_tx;

    localparam int TM    = 3;
    localparam int ONT   = 2;
    localparam int OFFT  = 2;
    localparam int LONGT = 6;
    localparam int GAPT  = 4;
    localparam int T     = TM + 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] value;
    logic       busy;
    logic       done;
    logic       led;

    int checks   = 0;
    int failures = 0;
    int idle_err = 0;
    int cyc      = 0;

    typedef struct {
        int v;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   acc;
    int   cur_lat;

    led_blink_code_tx #(
        .TICK_MAX  (TM),
        .ON_TICKS  (ONT),
        .OFF_TICKS (OFFT),
        .LONG_TICKS(LONGT),
        .GAP_TICKS (GAPT)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .start(start),
        .value(value),
        .busy (busy),
        .done (done),
        .led  (led)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // reference model: t = cycles since the accept edge (1 = first cycle after it)
    function automatic int blinks(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    function automatic int high_len(input int v);
        return ((v == 0) ? LONGT : ONT) * T;
    endfunction

    function automatic int code_lat(input int v);
        return blinks(v) * (high_len(v) + OFFT * T) + GAPT * T + 1;
    endfunction

    function automatic logic exp_led(input int v, input int t);
        int k;
        int per;
        k   = t - 1;
        per = high_len(v) + OFFT * T;
        if (k < 0 || k >= blinks(v) * per) return 1'b0;
        return ((k % per) < high_len(v)) ? 1'b1 : 1'b0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    initial begin : monitor
        bit   active;
        exp_t cur;
        int   t, lat, rises, wave_err, busy_err;
        logic prev_led;
        active   = 1'b0;
        prev_led = 1'b0;
        rises    = 0;
        wave_err = 0;
        busy_err = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active   = 1'b0;
                prev_led = 1'b0;
            end else begin
                if (!active && sb.size() > 0 && cyc == sb[0].acc + 1) begin
                    cur      = sb.pop_front();
                    active   = 1'b1;
                    rises    = 0;
                    wave_err = 0;
                    busy_err = 0;
                end
                if (active) begin
                    t   = cyc - cur.acc;
                    lat = code_lat(cur.v);
                    if (led === 1'b1 && prev_led !== 1'b1) rises++;
                    if (led !== exp_led(cur.v, t)) wave_err++;
                    if (busy !== ((t < lat) ? 1'b1 : 1'b0)) busy_err++;
                    if (done === 1'b1) begin
                        check("done_latency", t, lat);
                        check("rise_count", rises, blinks(cur.v));
                        check("led_wave_errs", wave_err, 0);
                        check("busy_errs", busy_err, 0);
                        active = 1'b0;
                    end else if (t >= lat + 2) begin
                        check("done_timeout", t, lat);
                        active = 1'b0;
                    end
                end else if (done !== 1'b0 || led !== 1'b0 || busy !== 1'b0) begin
                    idle_err++;
                end
                prev_led = led;
            end
        end
    end

    // called at a negedge; returns at the negedge of cycle t=1
    task automatic accept_code(input int v);
        start = 1'b1;
        value = 4'(v);
        @(posedge clk);
        #1;
        acc     = cyc - 1;
        cur_lat = code_lat(v);
        sb.push_back('{v: v, acc: acc});
        start = 1'b0;
        value = 4'($urandom);
        @(negedge clk);
    endtask

    task automatic wait_t(input int t);
        while (cyc - acc < t) @(negedge clk);
    endtask

    task automatic spam(input int t);
        wait_t(t);
        start = 1'b1;
        value = 4'($urandom);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic finish_code(input int idle);
        wait_t(cur_lat);
        repeat (idle) @(negedge clk);
    endtask

    task automatic async_reset(input int hold);
        rst = 1'b1;
        #1;
        check("rst_led", led, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        sb.delete();
        repeat (hold) begin
            @(negedge clk);
            check("rst_hold_quiet", {29'd0, led, busy, done}, 0);
        end
        rst = 1'b0;
    endtask

    initial begin
        int v, t1, t2;
        rst   = 1'b0;
        start = 1'b0;
        value = 4'd0;
        acc   = 0;
        #2;
        async_reset(3);
        repeat (2) @(negedge clk);

        accept_code(3);
        finish_code(3);

        accept_code(0);
        finish_code(3);

        accept_code(15);
        spam(5);
        spam(20);
        finish_code(0);
        accept_code(1);
        finish_code(4);

        accept_code(4);
        wait_t(20);
        check("pre_reset_led", led, exp_led(4, 20));
        async_reset(3);
        repeat (2) @(negedge clk);
        accept_code(2);
        finish_code(3);

        accept_code(1);
        finish_code(2);

        for (int i = 0; i < 16; i++) begin
            v = $urandom_range(0, 15);
            accept_code(v);
            if ($urandom_range(0, 1) == 1) begin
                t1 = $urandom_range(1, cur_lat / 2);
                t2 = $urandom_range(cur_lat / 2 + 1, cur_lat - 1);
                spam(t1);
                spam(t2);
            end
            wait_t(cur_lat);
            if ($urandom_range(0, 2) != 0) begin
                repeat ($urandom_range(1, 5)) @(negedge clk);
            end
        end

        repeat (10) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        check("idle_activity", idle_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
